// File: rtl/cinird_code_gen.sv
// CI / NI-riu2 / RD-riu2 code producer for the joint histogram.
// Three register stages: inputs+mu, bit patterns, codes; plus frame bookkeeping.
module cinird_code_gen #(
    parameter int DATA_W = 8,
    parameter int CNT_W  = 20
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                done_i,
    input  logic                last_i,
    input  logic [DATA_W-1:0]   center_i,
    input  logic [8*DATA_W-1:0] inner_i,
    input  logic [8*DATA_W-1:0] outer_i,
    input  logic [DATA_W-1:0]   mean_i,
    output logic                ci_o,
    output logic [3:0]          ni_o,
    output logic [3:0]          rd_o,
    output logic                done_o,
    output logic                progress_done_o,
    output logic [CNT_W-1:0]    frame_cnt_o
);

    function automatic logic [3:0] riu2(input logic [7:0] p);
        logic [7:0] t;
        logic [3:0] u;
        logic [3:0] ones;
        t    = p ^ {p[0], p[7:1]};
        u    = '0;
        ones = '0;
        for (int i = 0; i < 8; i++) begin
            u    = u + 4'(t[i]);
            ones = ones + 4'(p[i]);
        end
        return (u <= 4'd2) ? ones : 4'd9;
    endfunction

    // stage 1
    logic                s1_vld_q, s1_vld_d, s1_last_q, s1_last_d;
    logic [DATA_W-1:0]   s1_center_q, s1_center_d, s1_mean_q, s1_mean_d, s1_mu_q, s1_mu_d;
    logic [8*DATA_W-1:0] s1_inner_q, s1_inner_d, s1_outer_q, s1_outer_d;
    // stage 2
    logic                s2_vld_q, s2_vld_d, s2_last_q, s2_last_d;
    logic                s2_ci_q, s2_ci_d;
    logic [7:0]          s2_ni_q, s2_ni_d, s2_rd_q, s2_rd_d;
    // stage 3 / outputs
    logic                s3_vld_q, s3_vld_d, s3_last_q, s3_last_d;
    logic                ci_q, ci_d;
    logic [3:0]          ni_q, ni_d, rd_q, rd_d;
    logic                prog_q, prog_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                new_frame_q, new_frame_d;

    logic [DATA_W+2:0]   sum;
    logic                frame_start;

    always_comb begin
        sum = '0;
        for (int k = 0; k < 8; k++)
            sum = sum + (DATA_W+3)'(inner_i[DATA_W*k +: DATA_W]);
        s1_vld_d    = done_i;
        s1_last_d   = done_i & last_i;
        s1_center_d = center_i;
        s1_mean_d   = mean_i;
        s1_inner_d  = inner_i;
        s1_outer_d  = outer_i;
        s1_mu_d     = sum[DATA_W+2:3];
    end

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_last_d = s1_last_q;
        s2_ci_d   = (s1_center_q >= s1_mean_q);
        s2_ni_d   = '0;
        s2_rd_d   = '0;
        for (int k = 0; k < 8; k++) begin
            s2_ni_d[k] = (s1_inner_q[DATA_W*k +: DATA_W] >= s1_mu_q);
            s2_rd_d[k] = (s1_outer_q[DATA_W*k +: DATA_W] >= s1_inner_q[DATA_W*k +: DATA_W]);
        end
    end

    // A frame restarts the counter if the previous emitted code closed a frame,
    // either on the cycle right after it or later after a gap.
    assign frame_start = new_frame_q | (s3_vld_q & s3_last_q);

    always_comb begin
        s3_vld_d    = s2_vld_q;
        s3_last_d   = s2_last_q;
        ci_d        = ci_q;
        ni_d        = ni_q;
        rd_d        = rd_q;
        cnt_d       = cnt_q;
        new_frame_d = frame_start;
        prog_d      = s3_vld_q & s3_last_q;
        if (s2_vld_q) begin
            ci_d        = s2_ci_q;
            ni_d        = riu2(s2_ni_q);
            rd_d        = riu2(s2_rd_q);
            new_frame_d = 1'b0;
            if (frame_start)
                cnt_d = CNT_W'(1);
            else if (cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q    <= 1'b0;
            s1_last_q   <= 1'b0;
            s1_center_q <= '0;
            s1_mean_q   <= '0;
            s1_mu_q     <= '0;
            s1_inner_q  <= '0;
            s1_outer_q  <= '0;
            s2_vld_q    <= 1'b0;
            s2_last_q   <= 1'b0;
            s2_ci_q     <= 1'b0;
            s2_ni_q     <= '0;
            s2_rd_q     <= '0;
            s3_vld_q    <= 1'b0;
            s3_last_q   <= 1'b0;
            ci_q        <= 1'b0;
            ni_q        <= '0;
            rd_q        <= '0;
            prog_q      <= 1'b0;
            cnt_q       <= '0;
            new_frame_q <= 1'b0;
        end else begin
            s1_vld_q    <= s1_vld_d;
            s1_last_q   <= s1_last_d;
            s1_center_q <= s1_center_d;
            s1_mean_q   <= s1_mean_d;
            s1_mu_q     <= s1_mu_d;
            s1_inner_q  <= s1_inner_d;
            s1_outer_q  <= s1_outer_d;
            s2_vld_q    <= s2_vld_d;
            s2_last_q   <= s2_last_d;
            s2_ci_q     <= s2_ci_d;
            s2_ni_q     <= s2_ni_d;
            s2_rd_q     <= s2_rd_d;
            s3_vld_q    <= s3_vld_d;
            s3_last_q   <= s3_last_d;
            ci_q        <= ci_d;
            ni_q        <= ni_d;
            rd_q        <= rd_d;
            prog_q      <= prog_d;
            cnt_q       <= cnt_d;
            new_frame_q <= new_frame_d;
        end
    end

    assign ci_o            = ci_q;
    assign ni_o            = ni_q;
    assign rd_o            = rd_q;
    assign done_o          = s3_vld_q;
    assign progress_done_o = prog_q;
    assign frame_cnt_o     = cnt_q;

endmodule

// File: tb/tb_cinird_code_gen.sv
// Directed bench for cinird_code_gen; counter narrowed to 3 bits to reach saturation.
module tb_cinird_code_gen;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 3;

    logic                clk = 1'b0;
    logic                rst;
    logic                done_i, last_i;
    logic [DATA_W-1:0]   center_i, mean_i;
    logic [8*DATA_W-1:0] inner_i, outer_i;
    logic                ci_o, done_o, progress_done_o;
    logic [3:0]          ni_o, rd_o;
    logic [CNT_W-1:0]    frame_cnt_o;

    int tests = 0;
    int fails = 0;

    cinird_code_gen #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .done_i(done_i), .last_i(last_i),
        .center_i(center_i), .inner_i(inner_i), .outer_i(outer_i), .mean_i(mean_i),
        .ci_o(ci_o), .ni_o(ni_o), .rd_o(rd_o), .done_o(done_o),
        .progress_done_o(progress_done_o), .frame_cnt_o(frame_cnt_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; done_i = 1'b0; last_i = 1'b0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic set_win(input logic [7:0] c, input logic [7:0] m,
                           input logic [63:0] inn, input logic [63:0] out);
        center_i = c; mean_i = m; inner_i = inn; outer_i = out;
    endtask

    initial begin
        rst = 1'b1; done_i = 1'b0; last_i = 1'b0;
        set_win(8'd0, 8'd0, 64'd0, 64'd0);
        do_reset();
        chk("rst_done", 32'(done_o), 0);
        chk("rst_prog", 32'(progress_done_o), 0);
        chk("rst_cnt",  32'(frame_cnt_o), 0);
        chk("rst_codes", {23'd0, ci_o, ni_o, rd_o}, 0);

        // 1: flat window
        set_win(8'd100, 8'd100, {8{8'd100}}, {8{8'd100}});
        done_i = 1'b1; tick(); done_i = 1'b0;
        tick();
        chk("t1_early", 32'(done_o), 0);
        tick();
        chk("t1_done", 32'(done_o), 1);
        chk("t1_ci", 32'(ci_o), 1);
        chk("t1_ni", 32'(ni_o), 8);
        chk("t1_rd", 32'(rd_o), 8);
        chk("t1_cnt", 32'(frame_cnt_o), 1);

        // 2: single bright inner neighbour
        set_win(8'd50, 8'd100, {56'd0, 8'd200}, {56'd0, 8'd200});
        done_i = 1'b1; tick(); done_i = 1'b0; tick(); tick();
        chk("t2_done", 32'(done_o), 1);
        chk("t2_ci", 32'(ci_o), 0);
        chk("t2_ni", 32'(ni_o), 1);
        chk("t2_rd", 32'(rd_o), 8);
        chk("t2_cnt", 32'(frame_cnt_o), 2);

        // 3: alternating inner ring, zero outer ring -> both non-uniform
        set_win(8'd150, 8'd100, {4{8'd0, 8'd200}}, 64'd0);
        done_i = 1'b1; tick(); done_i = 1'b0; tick(); tick();
        chk("t3_ci", 32'(ci_o), 1);
        chk("t3_ni", 32'(ni_o), 9);
        chk("t3_rd", 32'(rd_o), 9);
        tick();
        chk("t3_gap_done", 32'(done_o), 0);
        chk("t3_hold_ni", 32'(ni_o), 9);

        // 4: five back-to-back windows, last on the fifth
        do_reset();
        set_win(8'd100, 8'd100, {8{8'd100}}, {8{8'd100}});
        for (int i = 0; i < 10; i++) begin
            done_i = (i < 5); last_i = (i == 4);
            tick();
            chk($sformatf("t4_done%0d", i), 32'(done_o), 32'(i >= 2 && i <= 6));
            chk($sformatf("t4_prog%0d", i), 32'(progress_done_o), 32'(i == 7));
            if (i >= 2 && i <= 6) chk($sformatf("t4_cnt%0d", i), 32'(frame_cnt_o), 32'(i - 1));
        end
        chk("t4_final_cnt", 32'(frame_cnt_o), 5);

        // 5: two frames of three, no gap
        do_reset();
        for (int i = 0; i < 10; i++) begin
            done_i = (i < 6); last_i = (i == 2 || i == 5);
            tick();
            chk($sformatf("t5_done%0d", i), 32'(done_o), 32'(i >= 2 && i <= 7));
            chk($sformatf("t5_prog%0d", i), 32'(progress_done_o), 32'(i == 5 || i == 8));
            if (i >= 2 && i <= 7)
                chk($sformatf("t5_cnt%0d", i), 32'(frame_cnt_o), 32'((i <= 4) ? i - 1 : i - 4));
        end

        // 6: reset with windows in flight, then a stray last_i
        set_win(8'd50, 8'd100, {56'd0, 8'd200}, {56'd0, 8'd200});
        done_i = 1'b1; last_i = 1'b0; tick();
        tick();
        last_i = 1'b1; rst = 1'b1; tick();
        rst = 1'b0; done_i = 1'b0; last_i = 1'b0;
        tick();
        last_i = 1'b1; tick(); last_i = 1'b0;
        for (int i = 0; i < 6; i++) begin
            chk($sformatf("t6_done%0d", i), 32'(done_o), 0);
            chk($sformatf("t6_prog%0d", i), 32'(progress_done_o), 0);
            tick();
        end
        chk("t6_codes", {23'd0, ci_o, ni_o, rd_o}, 0);
        chk("t6_cnt", 32'(frame_cnt_o), 0);
        done_i = 1'b1; last_i = 1'b1; tick(); done_i = 1'b0; last_i = 1'b0;
        tick(); tick();
        chk("t6_fresh_done", 32'(done_o), 1);
        chk("t6_fresh_cnt", 32'(frame_cnt_o), 1);
        tick();
        chk("t6_fresh_prog", 32'(progress_done_o), 1);

        // 7: counter saturation with a 9-window frame
        do_reset();
        for (int i = 0; i < 12; i++) begin
            done_i = (i < 9); last_i = (i == 8);
            tick();
            if (i >= 2 && i <= 10)
                chk($sformatf("t7_cnt%0d", i), 32'(frame_cnt_o), 32'((i - 1 > 7) ? 7 : i - 1));
        end
        chk("t7_sat", 32'(frame_cnt_o), 7);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
